mux_seq_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 4:1 serialising mux. It accepts 4-bit words over a valid/ready handshake and holds each word on the mux data inputs `w0`..`w3`. It then steps the mux select so the mux output `y` presents the word MSB-first (`sel` 00 selects `w3`, 11 selects `w0`). Each bit lasts a programmable number of clocks, and words stream back-to-back with no bubble.

---
 rtl/mux_seq_ctrl_pkg.sv | 41 ++++
 rtl/mux_seq_ctrl_if.sv | 30 +++
 rtl/mux_seq_ctrl_timer.sv | 47 ++++
 rtl/mux_seq_ctrl.sv | 114 +++++++++++
 tb/tb_mux_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mux_seq_pkg
//
// Shared definitions for the 4:1 serialising-mux sequencer and anything that
// models the mux downstream of it.
//
//   state_t    : sequencer FSM states (IDLE, SHIFT)
//   SEL_FIRST  : select value for the first bit of a word
//   SEL_LAST   : select value for the fourth (final) bit of a word
//   SEL_W3..W0 : mux mapping, sel 00 picks w3 (MSB) ... sel 11 picks w0 (LSB)
//   mux_pick() : reference behaviour of the 4:1 mux using that mapping
// -----------------------------------------------------------------------------
package mux_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] SEL_FIRST = 2'b00;
    localparam logic [1:0] SEL_LAST  = 2'b11;

    // Word is sent MSB-first, so the select counts up while the bit index
    // counts down.
    localparam logic [1:0] SEL_W3 = 2'b00;
    localparam logic [1:0] SEL_W2 = 2'b01;
    localparam logic [1:0] SEL_W1 = 2'b10;
    localparam logic [1:0] SEL_W0 = 2'b11;

    function automatic logic mux_pick(input logic [1:0] sel, input logic [3:0] w);
        logic y;
        case (sel)
            SEL_W3:  y = w[3];
            SEL_W2:  y = w[2];
            SEL_W1:  y = w[1];
            default: y = w[0];
        endcase
        return y;
    endfunction

endpackage

// File: rtl/mux_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mux_seq_ctrl_if
//
// Upstream word handshake into the sequencer.
//
//   in_valid : upstream word valid          (master -> slave)
//   in_data  : 4-bit word, bit 3 sent first (master -> slave)
//   in_ready : sequencer can take a word    (slave  -> master)
//
// Modports: master = word producer, slave = mux_seq_ctrl.
// -----------------------------------------------------------------------------
interface mux_seq_ctrl_if;

    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/mux_seq_ctrl_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
//
// Bit-period counter for the serialising sequencer. Counts 0..DIV-1 while
// 'run' is high and flags the final clock of each bit period with 'tick'.
// The counter wraps to 0 on its own at tick, so it always rests at 0 once
// the sequencer returns to IDLE.
//
// Parameters:
//   DIV : clocks per serial bit, 1..256
//   CW  : counter width, $clog2(DIV) with a floor of 1 (derived)
//
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset
//   clear in   force the counter to 0 (new word loaded)
//   run   in   advance the counter
//   tick  out  counter is at DIV-1 (last clock of the bit period)
// -----------------------------------------------------------------------------
module bit_timer #(
    parameter  int DIV = 1,
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    logic [CW-1:0] cnt;

    // With DIV=1 this compares against 0, so cnt never leaves 0 and tick is
    // high on every running cycle.
    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mux_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mux_seq_ctrl
//
// Sequencer sitting directly upstream of a 4:1 serialising mux. Accepts 4-bit
// words over a valid/ready handshake, holds each word on the mux data inputs
// w0..w3 and steps the mux select so the mux output carries the word
// MSB-first, each bit lasting DIV clocks. Words stream back-to-back: the next
// word is accepted on the final clock of the current word's last bit.
//
// Optional feature (compile-time macro MUX_SEQ_PARITY_EN):
//   adds 'par' (even parity of the accepted word, registered at accept) and
//   'par_valid' (final strobe of the word). Undefined by default.
//
// Parameters:
//   DIV : clocks per serial bit, 1..256
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   up         if   word handshake (in_valid, in_data, in_ready), slave side
//   w0..w3     out  registered copy of the accepted word, to mux data inputs
//   sel        out  registered mux select (00 -> w3 ... 11 -> w0)
//   bit_valid  out  a word is being serialised
//   bit_strobe out  final clock of each bit period (downstream sample point)
//   bit_last   out  fourth bit period of the word
//   par        out  [MUX_SEQ_PARITY_EN] parity of the word being sent
//   par_valid  out  [MUX_SEQ_PARITY_EN] bit_last & bit_strobe
// -----------------------------------------------------------------------------
module mux_seq_ctrl
    import mux_seq_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_seq_ctrl_if.slave  up,
    output logic           w0,
    output logic           w1,
    output logic           w2,
    output logic           w3,
    output logic [1:0]     sel,
    output logic           bit_valid,
    output logic           bit_strobe,
    output logic           bit_last
`ifdef MUX_SEQ_PARITY_EN
    ,
    output logic           par,
    output logic           par_valid
`endif
);

    state_t state;
    logic   shifting;
    logic   tick;
    logic   accept;

    assign shifting = (state == SHIFT);

    // Ready is independent of in_valid: idle, or the very last clock of the
    // word so the next one loads with no bubble.
    assign up.in_ready = !shifting || ((sel == SEL_LAST) && tick);
    assign accept      = up.in_valid && up.in_ready;

    bit_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .run   (shifting),
        .tick  (tick)
    );

    assign bit_valid  = shifting;
    assign bit_strobe = shifting && tick;
    assign bit_last   = shifting && (sel == SEL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= SEL_FIRST;
            w0    <= 1'b0;
            w1    <= 1'b0;
            w2    <= 1'b0;
            w3    <= 1'b0;
`ifdef MUX_SEQ_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (accept) begin
            state <= SHIFT;
            sel   <= SEL_FIRST;
            w0    <= up.in_data[0];
            w1    <= up.in_data[1];
            w2    <= up.in_data[2];
            w3    <= up.in_data[3];
`ifdef MUX_SEQ_PARITY_EN
            par   <= ^up.in_data;
`endif
        end else if (shifting && tick) begin
            if (sel != SEL_LAST) begin
                sel <= sel + 2'd1;
            end else begin
                // Word finished with nothing queued: park, keep w0..w3.
                state <= IDLE;
                sel   <= SEL_FIRST;
            end
        end
    end

`ifdef MUX_SEQ_PARITY_EN
    assign par_valid = bit_last && bit_strobe;
`endif

endmodule

// File: tb/tb_mux_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_seq_ctrl
//
// Three sequencers (DIV = 1, 2, 3) each feeding a 4:1 mux. A word-level model
// (busy flag + clocks elapsed since accept) predicts every output each cycle;
// directed scenarios add hand-computed literal expectations on the serial
// stream and on handshake/valid counts. Build with +define+MUX_SEQ_PARITY_EN
// to include the parity outputs.
// -----------------------------------------------------------------------------
module tb_mux_seq_ctrl;
    import mux_seq_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic run_chk = 1'b0;

    logic       in_valid_a [3];
    logic [3:0] in_data_a  [3];

    wire        rdy_a [3];
    wire [3:0]  w_a   [3];
    wire [1:0]  sel_a [3];
    wire        bv_a  [3];
    wire        bs_a  [3];
    wire        bl_a  [3];
    wire        y_a   [3];
`ifdef MUX_SEQ_PARITY_EN
    wire        par_a [3];
    wire        pv_a  [3];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gd
        mux_seq_ctrl_if ifc ();
        logic       w0, w1, w2, w3;
        logic [1:0] sel;
        logic       bv, bs, bl;
`ifdef MUX_SEQ_PARITY_EN
        logic       par, pv;
`endif
        assign ifc.in_valid = in_valid_a[g];
        assign ifc.in_data  = in_data_a[g];

        mux_seq_ctrl #(.DIV(g + 1)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .up         (ifc),
            .w0         (w0),
            .w1         (w1),
            .w2         (w2),
            .w3         (w3),
            .sel        (sel),
            .bit_valid  (bv),
            .bit_strobe (bs),
            .bit_last   (bl)
`ifdef MUX_SEQ_PARITY_EN
            ,
            .par        (par),
            .par_valid  (pv)
`endif
        );

        assign rdy_a[g] = ifc.in_ready;
        assign w_a[g]   = {w3, w2, w1, w0};
        assign sel_a[g] = sel;
        assign bv_a[g]  = bv;
        assign bs_a[g]  = bs;
        assign bl_a[g]  = bl;
        // the downstream serialising mux
        assign y_a[g]   = mux_pick(sel, {w3, w2, w1, w0});
`ifdef MUX_SEQ_PARITY_EN
        assign par_a[g] = par;
        assign pv_a[g]  = pv;
`endif
    end

    // ---------------- word-level model ----------------
    bit         m_busy [3];
    int         m_pos  [3];   // clocks since the accept edge
    logic [3:0] m_word [3];
    logic       m_par  [3];

    function automatic int div_of(int i);
        return i + 1;
    endfunction

    function automatic logic exp_ready(int i);
        return !m_busy[i] || (m_pos[i] == 4 * div_of(i) - 1);
    endfunction

    function automatic logic [1:0] exp_sel(int i);
        return m_busy[i] ? 2'(m_pos[i] / div_of(i)) : 2'b00;
    endfunction

    function automatic logic exp_strobe(int i);
        return m_busy[i] && (m_pos[i] % div_of(i) == div_of(i) - 1);
    endfunction

    function automatic logic exp_last(int i);
        return m_busy[i] && (m_pos[i] / div_of(i) == 3);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_busy[i] <= 1'b0;
                m_pos[i]  <= 0;
                m_word[i] <= 4'h0;
                m_par[i]  <= 1'b0;
            end else if (in_valid_a[i] && exp_ready(i)) begin
                m_busy[i] <= 1'b1;
                m_pos[i]  <= 0;
                m_word[i] <= in_data_a[i];
                m_par[i]  <= ^in_data_a[i];
            end else if (m_busy[i]) begin
                if (m_pos[i] == 4 * div_of(i) - 1) m_busy[i] <= 1'b0;
                else                               m_pos[i]  <= m_pos[i] + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    int          cnt_bv [3];
    int          cnt_bvr[3];
    int          cnt_bs [3];
    int          cnt_bl [3];
    int          cnt_rb [3];
    int          cnt_pv [3];
    int          ycnt   [3];
    logic [31:0] ybits  [3];
    logic        prev_bv[3];

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            cnt_bv[i] = 0; cnt_bvr[i] = 0; cnt_bs[i] = 0; cnt_bl[i] = 0;
            cnt_rb[i] = 0; cnt_pv[i] = 0; ycnt[i] = 0; ybits[i] = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) prev_bv[i] = 1'b0;
        forever begin
            @(negedge clk);
            if (run_chk) begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("d%0d.in_ready", i),   32'(rdy_a[i]), 32'(exp_ready(i)));
                    chk($sformatf("d%0d.sel", i),        32'(sel_a[i]), 32'(exp_sel(i)));
                    chk($sformatf("d%0d.w", i),          32'(w_a[i]),   32'(m_word[i]));
                    chk($sformatf("d%0d.bit_valid", i),  32'(bv_a[i]),  32'(m_busy[i]));
                    chk($sformatf("d%0d.bit_strobe", i), 32'(bs_a[i]),  32'(exp_strobe(i)));
                    chk($sformatf("d%0d.bit_last", i),   32'(bl_a[i]),  32'(exp_last(i)));
                    if (exp_strobe(i))
                        chk($sformatf("d%0d.y", i), 32'(y_a[i]),
                            32'(m_word[i][3 - int'(exp_sel(i))]));
`ifdef MUX_SEQ_PARITY_EN
                    chk($sformatf("d%0d.par", i),       32'(par_a[i]), 32'(m_par[i]));
                    chk($sformatf("d%0d.par_valid", i), 32'(pv_a[i]),
                        32'(exp_last(i) && exp_strobe(i)));
                    if (pv_a[i]) cnt_pv[i]++;
`endif
                    if (bv_a[i]) cnt_bv[i]++;
                    if (bv_a[i] && !prev_bv[i]) cnt_bvr[i]++;
                    prev_bv[i] = bv_a[i];
                    if (bs_a[i]) begin
                        cnt_bs[i]++;
                        ybits[i] = {ybits[i][30:0], y_a[i]};
                        ycnt[i]++;
                    end
                    if (bl_a[i]) cnt_bl[i]++;
                    if (rdy_a[i] && bv_a[i]) cnt_rb[i]++;
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i] = 1'b0;
            in_data_a[i]  = 4'h0;
        end
        clear_counts();

        // Reset, then idle for 10 cycles
        repeat (3) @(posedge clk);
        #1 run_chk = 1'b1;
        @(negedge clk); #1;
        rst_n = 1'b1;
        clear_counts();
        repeat (10) @(negedge clk);
        #1;
        chk("idle.in_ready", 32'(rdy_a[0]), 32'd1);
        chk("idle.sel",      32'(sel_a[0]), 32'd0);
        chk("idle.w",        32'(w_a[0]),   32'd0);
        chk("idle.bv_cycles", 32'(cnt_bv[0] + cnt_bv[1] + cnt_bv[2]), 32'd0);

        // Single word, DIV=1
        clear_counts();
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 4'b1011;
        @(negedge clk); #1;
        in_valid_a[0] = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("single.nbits",    32'(ycnt[0]),       32'd4);
        chk("single.stream",   32'(ybits[0][3:0]), 32'b1011);
        chk("single.last_cyc", 32'(cnt_bl[0]),     32'd1);
        chk("single.bv_cyc",   32'(cnt_bv[0]),     32'd4);
        chk("single.idle",     32'(bv_a[0]),       32'd0);

        // Back-to-back, DIV=3: 0xA then 0x5 with valid held
        clear_counts();
        in_valid_a[2] = 1'b1;
        in_data_a[2]  = 4'hA;
        @(negedge clk); #1;
        in_data_a[2]  = 4'h5;
        repeat (12) @(negedge clk);
        #1;
        in_valid_a[2] = 1'b0;
        repeat (14) @(negedge clk);
        #1;
        chk("b2b.nbits",     32'(ycnt[2]),       32'd8);
        chk("b2b.stream",    32'(ybits[2][7:0]), 32'hA5);
        chk("b2b.bv_cyc",    32'(cnt_bv[2]),     32'd24);
        chk("b2b.bv_runs",   32'(cnt_bvr[2]),    32'd1);
        chk("b2b.rdy_pulse", 32'(cnt_rb[2]),     32'd2);

        // Stall, DIV=2: 0x0 accepted, 0xF presented one clock later
        clear_counts();
        in_valid_a[1] = 1'b1;
        in_data_a[1]  = 4'h0;
        @(negedge clk); #1;
        in_valid_a[1] = 1'b0;
        @(negedge clk); #1;
        in_valid_a[1] = 1'b1;
        in_data_a[1]  = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        chk("stall.w_held",  32'(w_a[1]),  32'h0);
        chk("stall.blocked", 32'(rdy_a[1]), 32'd0);
        repeat (4) @(negedge clk);
        #1;
        chk("stall.w_next",  32'(w_a[1]),  32'hF);
        in_valid_a[1] = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("stall.nbits",   32'(ycnt[1]),       32'd8);
        chk("stall.stream",  32'(ybits[1][7:0]), 32'h0F);
        chk("stall.bv_cyc",  32'(cnt_bv[1]),     32'd16);
        chk("stall.bv_runs", 32'(cnt_bvr[1]),    32'd1);

        // Reset mid-word, DIV=3, asserted while sel=10
        in_valid_a[2] = 1'b1;
        in_data_a[2]  = 4'h9;
        @(negedge clk); #1;
        in_valid_a[2] = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        chk("rst.pre_sel", 32'(sel_a[2]), 32'b10);
        rst_n = 1'b0;
        #1;
        chk("rst.sel",    32'(sel_a[2]), 32'd0);
        chk("rst.w",      32'(w_a[2]),   32'd0);
        chk("rst.bv",     32'(bv_a[2]),  32'd0);
        chk("rst.bs",     32'(bs_a[2]),  32'd0);
        chk("rst.bl",     32'(bl_a[2]),  32'd0);
        chk("rst.rdy",    32'(rdy_a[2]), 32'd1);
        clear_counts();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("rst.no_strobe", 32'(cnt_bs[2]), 32'd0);
        chk("rst.no_valid",  32'(cnt_bv[2]), 32'd0);

`ifdef MUX_SEQ_PARITY_EN
        // Parity, DIV=1: 0111 then 0110 back-to-back
        clear_counts();
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 4'b0111;
        @(negedge clk); #1;
        chk("par.first", 32'(par_a[0]), 32'd1);
        in_data_a[0]  = 4'b0110;
        repeat (4) @(negedge clk);
        #1;
        chk("par.second", 32'(par_a[0]), 32'd0);
        in_valid_a[0] = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("par.pulses", 32'(cnt_pv[0]), 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
